// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the sequential restoring divider.
package div_sequencer_pkg;
   localparam int DEF_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;
endpackage

// File: rtl/addsub_unit.sv
// Ripple add/sub: Mod=1 inverts B, so with Cin=1 it computes A-B and Cout=1 means no borrow.
module addsub_unit #(
   parameter int WIDTH = 9
) (
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   input  logic             Mod,
   output logic [WIDTH-1:0] S,
   output logic             Cout
);
   logic [WIDTH-1:0] b_eff;

   assign b_eff     = Mod ? ~B : B;
   assign {Cout, S} = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, Cin};
endmodule

// File: rtl/div_sequencer.sv
// Unsigned restoring divider, one quotient bit per cycle through a single add/sub unit.
module div_sequencer
   import div_sequencer_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Start,
   input  logic [WIDTH-1:0] Dividend,
   input  logic [WIDTH-1:0] Divisor,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Quotient,
   output logic [WIDTH-1:0] Remainder,
   output logic             DivZero
);
   localparam int CW = $clog2(WIDTH + 1);

   state_t           state, next_state;
   logic [WIDTH:0]   rem, shifted, trial;
   logic [WIDTH-1:0] dvd, dsr;
   logic [CW-1:0]    cnt;
   logic             dz, cout;
   logic             load, zero_load, step, finish;

   // dvd doubles as the quotient register: dividend bits shift out the top, quotient bits in the bottom.
   assign shifted = (rem << 1) | {{WIDTH{1'b0}}, dvd[WIDTH-1]};

   addsub_unit #(.WIDTH(WIDTH + 1)) u_addsub (
      .A    (shifted),
      .B    ({1'b0, dsr}),
      .Cin  (1'b1),
      .Mod  (1'b1),
      .S    (trial),
      .Cout (cout)
   );

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      load       = 1'b0;
      zero_load  = 1'b0;
      step       = 1'b0;
      finish     = 1'b0;
      case (state)
         IDLE: begin
            if (Start) begin
               if (Divisor == '0) begin
                  zero_load  = 1'b1;
                  next_state = DONE;
               end else begin
                  load       = 1'b1;
                  next_state = CALC;
               end
            end
         end
         CALC: begin
            step = 1'b1;
            if (cnt == CW'(1)) next_state = DONE;
         end
         DONE: begin
            finish     = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         rem       <= '0;
         dvd       <= '0;
         dsr       <= '0;
         cnt       <= '0;
         dz        <= 1'b0;
         Done      <= 1'b0;
         Quotient  <= '0;
         Remainder <= '0;
         DivZero   <= 1'b0;
      end else begin
         Done <= finish;
         if (load) begin
            dvd <= Dividend;
            dsr <= Divisor;
            rem <= '0;
            cnt <= CW'(WIDTH);
            dz  <= 1'b0;
         end else if (zero_load) begin
            dvd <= '1;
            rem <= {1'b0, Dividend};
            cnt <= '0;
            dz  <= 1'b1;
         end else if (step) begin
            rem <= cout ? trial : shifted;
            dvd <= {dvd[WIDTH-2:0], cout};
            cnt <= cnt - 1'b1;
         end
         if (finish) begin
            Quotient  <= dvd;
            Remainder <= rem[WIDTH-1:0];
            DivZero   <= dz;
         end
      end
   end

   assign Busy = (state != IDLE);
endmodule

// File: tb/tb_div_sequencer.sv
// Directed scoreboard bench for div_sequencer (WIDTH=8).
module tb_div_sequencer;
   logic       Clk = 1'b0;
   logic       Rst = 1'b1;
   logic       Start = 1'b0;
   logic [7:0] Dividend = '0;
   logic [7:0] Divisor = '0;
   logic       Busy, Done, DivZero;
   logic [7:0] Quotient, Remainder;

   typedef struct {
      logic [7:0] q;
      logic [7:0] r;
      logic       dz;
      int         lat;
   } exp_t;

   exp_t sb[$];
   int   compared = 0;
   int   mismatched = 0;

   div_sequencer #(.WIDTH(8)) dut (
      .Clk       (Clk),
      .Rst       (Rst),
      .Start     (Start),
      .Dividend  (Dividend),
      .Divisor   (Divisor),
      .Busy      (Busy),
      .Done      (Done),
      .Quotient  (Quotient),
      .Remainder (Remainder),
      .DivZero   (DivZero)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input int obs, input int exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Drive one Start pulse, push the reference result; returns 1ns after the accepting edge.
   task automatic start_op(input logic [7:0] a, input logic [7:0] b, input bit push);
      exp_t e;
      @(negedge Clk);
      Start    = 1'b1;
      Dividend = a;
      Divisor  = b;
      if (push) begin
         if (b == 8'd0) begin
            e.q = 8'hFF; e.r = a; e.dz = 1'b1; e.lat = 1;
         end else begin
            e.q = a / b; e.r = a % b; e.dz = 1'b0; e.lat = 9;
         end
         sb.push_back(e);
      end
      @(posedge Clk);
      #1;
      Start    = 1'b0;
      Dividend = 8'($urandom);
      Divisor  = 8'($urandom);
   endtask

   // Count edges until Done (bounded); lat=0 on timeout.
   task automatic wait_done(input int base, output int lat);
      int c;
      bit found;
      lat   = 0;
      found = 1'b0;
      c     = base;
      while (!found && c < base + 40) begin
         @(posedge Clk);
         #1;
         c++;
         if (Done) begin
            lat   = c;
            found = 1'b1;
         end
      end
   endtask

   task automatic pop_check(input string tag, input int lat);
      exp_t e;
      if (sb.size() == 0) begin
         check({tag, "_sb_nonempty"}, 0, 1);
      end else begin
         e = sb.pop_front();
         check({tag, "_latency"}, lat, e.lat);
         check({tag, "_quotient"}, int'(Quotient), int'(e.q));
         check({tag, "_remainder"}, int'(Remainder), int'(e.r));
         check({tag, "_divzero"}, int'(DivZero), int'(e.dz));
      end
   endtask

   task automatic run(input string tag, input logic [7:0] a, input logic [7:0] b);
      int lat;
      start_op(a, b, 1'b1);
      check({tag, "_busy"}, int'(Busy), 1);
      wait_done(0, lat);
      pop_check(tag, lat);
   endtask

   initial begin
      int lat, n;

      #12;
      check("rst_busy", int'(Busy), 0);
      check("rst_done", int'(Done), 0);
      check("rst_quotient", int'(Quotient), 0);
      check("rst_remainder", int'(Remainder), 0);
      check("rst_divzero", int'(DivZero), 0);
      @(negedge Clk);
      Rst = 1'b0;

      run("d200_7", 8'd200, 8'd7);
      @(posedge Clk); #1;
      check("done_one_cycle", int'(Done), 0);
      check("busy_after_done", int'(Busy), 0);
      Dividend = 8'd3; Divisor = 8'd1;
      repeat (3) @(posedge Clk);
      #1;
      check("hold_quotient", int'(Quotient), 28);
      check("hold_remainder", int'(Remainder), 4);

      run("d185_143", 8'd185, 8'd143);
      run("d255_129", 8'd255, 8'd129);
      run("d13_0", 8'd13, 8'd0);
      run("d1_200", 8'd1, 8'd200);
      run("d154_154", 8'd154, 8'd154);
      run("d255_1", 8'd255, 8'd1);

      // Second Start while busy must be ignored.
      start_op(8'd200, 8'd7, 1'b1);
      repeat (2) @(posedge Clk);
      start_op(8'd50, 8'd5, 1'b0);
      wait_done(3, lat);
      pop_check("busy_start", lat);
      n = 0;
      repeat (15) begin
         @(posedge Clk); #1;
         if (Done) n++;
      end
      check("busy_start_no_2nd_done", n, 0);

      // Reset mid-CALC aborts with no Done.
      start_op(8'd200, 8'd7, 1'b0);
      repeat (3) @(posedge Clk);
      #2;
      Rst = 1'b1;
      #1;
      check("abort_busy", int'(Busy), 0);
      check("abort_quotient", int'(Quotient), 0);
      check("abort_remainder", int'(Remainder), 0);
      check("abort_divzero", int'(DivZero), 0);
      @(negedge Clk);
      Rst = 1'b0;
      n = 0;
      repeat (15) begin
         @(posedge Clk); #1;
         if (Done) n++;
      end
      check("abort_no_done", n, 0);
      run("d100_9", 8'd100, 8'd9);

      check("sb_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
